// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: forwarding selects, wait-FSM states
// and the default register-address width.
package hazard_unit_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_unit_if.sv
// Status/control bundle between the pipeline stages (master) and the hazard unit (slave).
interface hazard_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
);

  logic [REG_AW-1:0]     Rs1D;
  logic [REG_AW-1:0]     Rs2D;
  logic [REG_AW-1:0]     Rs1E;
  logic [REG_AW-1:0]     Rs2E;
  logic [REG_AW-1:0]     RdE;
  logic [REG_AW-1:0]     RdM;
  logic [REG_AW-1:0]     RdW;
  logic                  ResultSrcE0;
  logic                  RegWriteM;
  logic                  RegWriteW;
  logic                  PCSrcE;
  logic                  MemBusyM;

  logic                  StallF;
  logic                  StallD;
  logic                  StallE;
  logic                  StallM;
  logic                  StallW;
  logic                  FlushD;
  logic                  FlushE;
  logic [1:0]            ForwardAE;
  logic [1:0]            ForwardBE;
  logic                  MemTimeout;
  logic [DATA_WIDTH-1:0] StallCycles;
  logic [DATA_WIDTH-1:0] RedirectCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemBusyM,
    input  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
    input  ForwardAE, ForwardBE, MemTimeout, StallCycles, RedirectCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemBusyM,
    output StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
    output ForwardAE, ForwardBE, MemTimeout, StallCycles, RedirectCnt
  );

endinterface

// File: rtl/hz_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module hz_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1'b1);

  logic [WIDTH-1:0] count_r;

  // Count register: clear wins, then increment unless already saturated
  always_ff @(posedge clk) begin
    if (clear) begin
      count_r <= {WIDTH{1'b0}};
    end else if (inc && (count_r != ALL_ONES)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stalls, redirect flushes, E-stage forwarding,
// data-memory freeze with wait-timeout FSM, and stall/redirect perf counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = REG_AW_DEF,
  parameter int MAX_WAIT   = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_unit_if.slave hz
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1'b1);
  localparam logic [WAIT_W-1:0] WAIT_0   = {WAIT_W{1'b0}};
  localparam logic [REG_AW-1:0] X0       = {REG_AW{1'b0}};

  hz_state_e             state_r;
  hz_state_e             state_nxt_s;
  logic [WAIT_W-1:0]     wait_cnt_r;
  logic [WAIT_W-1:0]     wait_cnt_nxt_s;
  logic                  timeout_r;
  logic                  timeout_nxt_s;

  logic                  lw_stall_s;
  logic                  stall_fd_s;
  logic                  freeze_s;
  logic                  flush_d_s;
  logic                  flush_e_s;
  fwd_sel_e              fwd_a_s;
  fwd_sel_e              fwd_b_s;
  logic                  redirect_commit_s;
  logic [DATA_WIDTH-1:0] stall_cycles_s;
  logic [DATA_WIDTH-1:0] redirect_cnt_s;

  // M-stage result is newer than W-stage, so it wins; x0 is hardwired and never forwarded
  function automatic fwd_sel_e fwd_pick(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              wr_m,
    input logic              wr_w
  );
    fwd_sel_e sel;
    sel = FWD_RF;
    if (wr_m && (rd_m != X0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (wr_w && (rd_w != X0) && (rd_w == rs)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // Load in E whose destination feeds the instruction in D
  always_comb begin
    lw_stall_s = 1'b0;
    if (hz.ResultSrcE0 && (hz.RdE != X0) &&
        ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D))) begin
      lw_stall_s = 1'b1;
    end else begin
      lw_stall_s = 1'b0;
    end
  end

  // Stall/flush decode; a memory freeze holds every stage and masks the load-use bubble
  always_comb begin
    stall_fd_s = 1'b0;
    flush_e_s  = 1'b0;
    freeze_s   = hz.MemBusyM;
    flush_d_s  = hz.PCSrcE;
    if (hz.MemBusyM) begin
      stall_fd_s = 1'b1;
      flush_e_s  = 1'b0;
    end else begin
      stall_fd_s = lw_stall_s;
      flush_e_s  = hz.PCSrcE | lw_stall_s;
    end
  end

  // Operand forwarding selects for both E-stage sources
  always_comb begin
    fwd_a_s = fwd_pick(hz.Rs1E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
    fwd_b_s = fwd_pick(hz.Rs2E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
  end

  // Wait FSM next state; the entry cycle is the first counted busy cycle
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    timeout_nxt_s  = timeout_r;
    case (state_r)
      RUN: begin
        if (hz.MemBusyM) begin
          state_nxt_s    = MEM_WAIT;
          wait_cnt_nxt_s = WAIT_ONE;
        end else begin
          state_nxt_s    = RUN;
          wait_cnt_nxt_s = WAIT_0;
        end
      end
      MEM_WAIT: begin
        if (!hz.MemBusyM) begin
          state_nxt_s    = RUN;
          wait_cnt_nxt_s = WAIT_0;
        end else if (wait_cnt_r != WAIT_MAX) begin
          state_nxt_s    = MEM_WAIT;
          wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
        end else begin
          state_nxt_s    = MEM_WAIT;
          wait_cnt_nxt_s = wait_cnt_r;
        end
      end
      default: begin
        state_nxt_s    = RUN;
        wait_cnt_nxt_s = WAIT_0;
      end
    endcase
    if (hz.MemBusyM && (wait_cnt_nxt_s == WAIT_MAX)) begin
      timeout_nxt_s = 1'b1;
    end else begin
      timeout_nxt_s = timeout_r;
    end
  end

  // FSM, wait counter and sticky timeout registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RUN;
      wait_cnt_r <= WAIT_0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      timeout_r  <= timeout_nxt_s;
    end
  end

  // A redirect held through a freeze commits only on the release cycle
  assign redirect_commit_s = hz.PCSrcE & ~hz.MemBusyM;

  hz_sat_counter #(.WIDTH(DATA_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (stall_fd_s),
    .count (stall_cycles_s)
  );

  hz_sat_counter #(.WIDTH(DATA_WIDTH)) u_redirect_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (redirect_commit_s),
    .count (redirect_cnt_s)
  );

  assign hz.StallF      = stall_fd_s;
  assign hz.StallD      = stall_fd_s;
  assign hz.StallE      = freeze_s;
  assign hz.StallM      = freeze_s;
  assign hz.StallW      = freeze_s;
  assign hz.FlushD      = flush_d_s;
  assign hz.FlushE      = flush_e_s;
  assign hz.ForwardAE   = fwd_a_s;
  assign hz.ForwardBE   = fwd_b_s;
  assign hz.MemTimeout  = timeout_r;
  assign hz.StallCycles = stall_cycles_s;
  assign hz.RedirectCnt = redirect_cnt_s;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and randomized bench for hazard_unit against a cycle-level behavioural model.
module tb_hazard_unit;

  localparam int DW  = 8;
  localparam int AW  = 5;
  localparam int MW  = 6;
  localparam int SAT = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_unit_if #(.DATA_WIDTH(DW), .REG_AW(AW)) hz ();

  hazard_unit #(.DATA_WIDTH(DW), .REG_AW(AW), .MAX_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int vectors     = 0;
  int miscompares = 0;

  // behavioural model state
  int m_run = 0;
  int m_sc  = 0;
  int m_rc  = 0;
  bit m_to  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1d, input logic [4:0] rs2d,
                        input logic [4:0] rs1e, input logic [4:0] rs2e,
                        input logic [4:0] rde, input logic [4:0] rdm, input logic [4:0] rdw,
                        input logic lde, input logic wm, input logic ww,
                        input logic pcs, input logic busy);
    hz.Rs1D = rs1d; hz.Rs2D = rs2d; hz.Rs1E = rs1e; hz.Rs2E = rs2e;
    hz.RdE = rde; hz.RdM = rdm; hz.RdW = rdw;
    hz.ResultSrcE0 = lde; hz.RegWriteM = wm; hz.RegWriteW = ww;
    hz.PCSrcE = pcs; hz.MemBusyM = busy;
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    logic [1:0] r;
    r = 2'b00;
    if (rs != 5'd0) begin
      if (hz.RegWriteW && (hz.RdW == rs)) r = 2'b01;
      if (hz.RegWriteM && (hz.RdM == rs)) r = 2'b10;
    end
    return r;
  endfunction

  // one clock: check combinational outputs, advance model, check registered outputs
  task automatic cycle(input string tag);
    logic lw, busy, pcs, r;
    #2;
    busy = hz.MemBusyM;
    pcs  = hz.PCSrcE;
    r    = rst;
    lw   = hz.ResultSrcE0 && (hz.RdE != 5'd0) && ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    chk({tag, ".StallF"}, 32'(hz.StallF), 32'(busy | lw));
    chk({tag, ".StallD"}, 32'(hz.StallD), 32'(busy | lw));
    chk({tag, ".StallE"}, 32'(hz.StallE), 32'(busy));
    chk({tag, ".StallM"}, 32'(hz.StallM), 32'(busy));
    chk({tag, ".StallW"}, 32'(hz.StallW), 32'(busy));
    chk({tag, ".FlushD"}, 32'(hz.FlushD), 32'(pcs));
    chk({tag, ".FlushE"}, 32'(hz.FlushE), 32'(busy ? 1'b0 : (pcs | lw)));
    chk({tag, ".FwdA"}, 32'(hz.ForwardAE), 32'(fwd_ref(hz.Rs1E)));
    chk({tag, ".FwdB"}, 32'(hz.ForwardBE), 32'(fwd_ref(hz.Rs2E)));
    @(posedge clk);
    if (r) begin
      m_run = 0; m_to = 1'b0; m_sc = 0; m_rc = 0;
    end else begin
      m_run = busy ? m_run + 1 : 0;
      if (m_run >= MW) m_to = 1'b1;
      if ((busy | lw) && (m_sc < SAT)) m_sc++;
      if (pcs && !busy && (m_rc < SAT)) m_rc++;
    end
    #1;
    chk({tag, ".MemTimeout"}, 32'(hz.MemTimeout), 32'(m_to));
    chk({tag, ".StallCycles"}, 32'(hz.StallCycles), 32'(m_sc));
    chk({tag, ".RedirectCnt"}, 32'(hz.RedirectCnt), 32'(m_rc));
  endtask

  initial begin
    int rc0;
    logic busy_q;
    rst = 1'b1;
    set_in(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("reset");
    cycle("reset");
    chk("reset.StallCycles", 32'(hz.StallCycles), 32'd0);
    chk("reset.RedirectCnt", 32'(hz.RedirectCnt), 32'd0);
    chk("reset.MemTimeout", 32'(hz.MemTimeout), 32'd0);
    rst = 1'b0;

    // load-use
    set_in(5'd5, 5'd1, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("lw.StallF", 32'(hz.StallF), 32'd1);
    chk("lw.FlushE", 32'(hz.FlushE), 32'd1);
    cycle("lw");
    chk("lw.StallCycles", 32'(hz.StallCycles), 32'd1);

    // forwarding: M beats W, x0 never forwarded
    set_in(5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    chk("fwd.AE_M", 32'(hz.ForwardAE), 32'd2);
    chk("fwd.BE_x0", 32'(hz.ForwardBE), 32'd0);
    cycle("fwd");
    set_in(5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    chk("fwd.AE_W", 32'(hz.ForwardAE), 32'd1);
    chk("fwd.BE_rdm0", 32'(hz.ForwardBE), 32'd0);
    cycle("fwd2");

    // redirect together with load-use
    rc0 = m_rc;
    set_in(5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    chk("redir_lw.FlushD", 32'(hz.FlushD), 32'd1);
    chk("redir_lw.FlushE", 32'(hz.FlushE), 32'd1);
    chk("redir_lw.StallF", 32'(hz.StallF), 32'd1);
    cycle("redir_lw");
    chk("redir_lw.RedirectCnt", 32'(hz.RedirectCnt), 32'(rc0 + 1));

    // 5-cycle freeze with redirect held: counts once on release
    rc0 = m_rc;
    for (int k = 0; k < 5; k++) begin
      set_in(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      cycle("freeze");
      chk("freeze.RedirectCnt", 32'(hz.RedirectCnt), 32'(rc0));
    end
    chk("freeze.MemTimeout", 32'(hz.MemTimeout), 32'd0);
    set_in(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("release");
    chk("release.RedirectCnt", 32'(hz.RedirectCnt), 32'(rc0 + 1));

    // timeout: sticky from the MW-th busy cycle onward
    for (int k = 1; k <= MW + 2; k++) begin
      set_in(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle("tmo");
      chk("tmo.MemTimeout", 32'(hz.MemTimeout), 32'(k >= MW));
    end
    set_in(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("tmo_rel");
    chk("tmo_rel.MemTimeout", 32'(hz.MemTimeout), 32'd1);

    // reset in the middle of a memory wait
    for (int k = 0; k < 3; k++) begin
      set_in(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle("pre_rst");
    end
    rst = 1'b1;
    cycle("mid_rst");
    chk("mid_rst.StallCycles", 32'(hz.StallCycles), 32'd0);
    chk("mid_rst.RedirectCnt", 32'(hz.RedirectCnt), 32'd0);
    chk("mid_rst.MemTimeout", 32'(hz.MemTimeout), 32'd0);
    rst = 1'b0;
    set_in(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("post_rst");

    // randomized traffic with bursty memory waits and occasional reset
    busy_q = 1'b0;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      busy_q = busy_q ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 5) == 0);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), busy_q);
      cycle("rand");
    end
    rst = 1'b0;

    // stall counter saturation
    for (int k = 0; k < SAT + 10; k++) begin
      set_in(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle("sat");
    end
    chk("sat.StallCycles", 32'(hz.StallCycles), 32'(SAT));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
